// File: rtl/ata_pio_ctrl_if.sv
// ata_pio_ctrl_if: 68k CPU-side bus bundle for the ATA PIO controller.
//   A[23:12]  CPU address (upper bits only)
//   RW_n      1 = read, 0 = write
//   AS_CPU_n  address strobe, asynchronous to C14M
//   DTACK_n   cycle-complete acknowledge back to the CPU
// master = CPU side, slave = controller side.
interface ata_pio_ctrl_if;
  logic [23:12] A;
  logic         RW_n;
  logic         AS_CPU_n;
  logic         DTACK_n;

  modport master (output A, output RW_n, output AS_CPU_n, input DTACK_n);
  modport slave  (input A, input RW_n, input AS_CPU_n, output DTACK_n);
endinterface

// File: rtl/ata_pio_ctrl.sv
// ata_pio_ctrl: Zorro IDE/boot-ROM decoder with programmable PIO timing.
// Decodes 68k cycles in the autoconfig window (A[23:16] == BASE_IDE) and
// runs either a boot-ROM read or an IDE PIO strobe sequence
// (setup / strobe / IORDY wait / hold), then acknowledges with DTACK_n.
// Ports:
//   C14M, RESET        clock, synchronous active-high reset
//   bus                CPU bus (A, RW_n, AS_CPU_n in; DTACK_n out)
//   BASE_IDE           autoconfig base compared with A[23:16]
//   IDE_CONFIGURED_n   0 enables decode
//   IDE_IORDY          shared drive ready, asynchronous
//   ROM_OE_n           boot ROM output enable
//   IDE_IOR_n/IOW_n    IDE read/write strobes
//   IDE_CS_n           {chN CS1,CS0 ... ch0 CS1,CS0}
//   IDE_ACCESS         high while an IDE cycle is in progress
//   IDE_TIMEOUT        sticky IORDY-wait expiry flag
module ata_pio_ctrl #(
  parameter int NUM_CHANNELS  = 1,
  parameter int SETUP_CYC     = 1,
  parameter int STROBE_CYC    = 3,
  parameter int HOLD_CYC      = 1,
  parameter int ROM_CYC       = 2,
  parameter int IORDY_TIMEOUT = 255
) (
  input  logic                      C14M,
  input  logic                      RESET,
  ata_pio_ctrl_if.slave             bus,
  input  logic [7:0]                BASE_IDE,
  input  logic                      IDE_CONFIGURED_n,
  input  logic                      IDE_IORDY,
  output logic                      ROM_OE_n,
  output logic                      IDE_IOR_n,
  output logic                      IDE_IOW_n,
  output logic [2*NUM_CHANNELS-1:0] IDE_CS_n,
  output logic                      IDE_ACCESS,
  output logic                      IDE_TIMEOUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROM, S_SETUP, S_STROBE, S_WAITRDY, S_HOLD, S_ACK
  } state_t;

  // One phase counter shared by ROM/SETUP/STROBE/HOLD, sized for the longest.
  localparam int M1   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int M2   = (HOLD_CYC > ROM_CYC) ? HOLD_CYC : ROM_CYC;
  localparam int PMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = (PMAX < 1) ? 1 : $clog2(PMAX + 1);
  localparam int WW   = (IORDY_TIMEOUT < 1) ? 1 : $clog2(IORDY_TIMEOUT + 1);

  localparam logic [CW-1:0] ROM_LAST    = CW'(ROM_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [WW-1:0] WAIT_MAX    = WW'(IORDY_TIMEOUT);
  localparam state_t        EXIT_ST     = (HOLD_CYC == 0) ? S_ACK : S_HOLD;
  localparam state_t        IDE_FIRST   = (SETUP_CYC == 0) ? S_STROBE : S_SETUP;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [1:0]      as_sync_q, rdy_sync_q;
  logic            rw_q, ch_q, ide_q, ide_en_n_q, to_q;
  logic [1:0]      cs_q;
  logic            as_s, rdy_s, hit, path_ide, lat, clr_en, set_to;

  assign as_s     = as_sync_q[1];
  assign rdy_s    = rdy_sync_q[1];
  assign hit      = !IDE_CONFIGURED_n && (bus.A[23:16] == BASE_IDE) && !as_s;
  // Writes always hit IDE; reads go to ROM until the first IDE write.
  assign path_ide = !bus.RW_n || !ide_en_n_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    wcnt_d  = wcnt_q + 1'b1;
    lat     = 1'b0;
    clr_en  = 1'b0;
    set_to  = 1'b0;
    unique case (state_q)
      S_IDLE: if (hit) begin
        lat     = 1'b1;
        clr_en  = !bus.RW_n;
        state_d = path_ide ? IDE_FIRST : S_ROM;
      end
      S_ROM:    if (cnt_q == ROM_LAST)   state_d = S_ACK;
      S_SETUP:  if (cnt_q == SETUP_LAST) state_d = S_STROBE;
      S_STROBE: if (cnt_q == STROBE_LAST) begin
        if (rdy_s) state_d = EXIT_ST;
        else if (IORDY_TIMEOUT == 0) begin
          state_d = EXIT_ST;
          set_to  = 1'b1;
        end else state_d = S_WAITRDY;
      end
      // wcnt_d is the number of wait cycles completed including this one.
      S_WAITRDY: if (rdy_s) state_d = EXIT_ST;
        else if (wcnt_d == WAIT_MAX) begin
          state_d = EXIT_ST;
          set_to  = 1'b1;
        end
      S_HOLD:   if (cnt_q == HOLD_LAST) state_d = S_ACK;
      S_ACK:    if (as_s) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // AS negation before ACK abandons the cycle silently.
    if (state_q != S_IDLE && state_q != S_ACK && as_s) begin
      state_d = S_IDLE;
      set_to  = 1'b0;
    end
    if (state_d != state_q) begin
      cnt_d  = '0;
      wcnt_d = '0;
    end
  end

  always_ff @(posedge C14M) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      as_sync_q  <= 2'b11;
      rdy_sync_q <= 2'b00;
      rw_q       <= 1'b1;
      ch_q       <= 1'b0;
      cs_q       <= 2'b11;
      ide_q      <= 1'b0;
      ide_en_n_q <= 1'b1;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      as_sync_q  <= {as_sync_q[0], bus.AS_CPU_n};
      rdy_sync_q <= {rdy_sync_q[0], IDE_IORDY};
      if (lat) begin
        rw_q  <= bus.RW_n;
        ch_q  <= (NUM_CHANNELS == 2) ? bus.A[14] : 1'b0;
        cs_q  <= {~bus.A[13], ~bus.A[12]};
        ide_q <= path_ide;
      end
      if (clr_en) ide_en_n_q <= 1'b0;
      if (set_to) to_q       <= 1'b1;
    end
  end

  // Outputs decode straight from the registered state, so IDLE is all-inactive.
  logic stb_on, cs_on;
  assign stb_on = ide_q && (state_q == S_STROBE || state_q == S_WAITRDY);
  assign cs_on  = ide_q && (state_q == S_SETUP || state_q == S_STROBE ||
                            state_q == S_WAITRDY || state_q == S_HOLD ||
                            state_q == S_ACK);

  assign ROM_OE_n    = !(!ide_q && (state_q == S_ROM || state_q == S_ACK));
  assign IDE_IOR_n   = !(stb_on && rw_q);
  assign IDE_IOW_n   = !(stb_on && !rw_q);
  assign IDE_ACCESS  = ide_q && (state_q != S_IDLE);
  assign IDE_TIMEOUT = to_q;
  assign bus.DTACK_n = !(state_q == S_ACK);

  always_comb begin
    IDE_CS_n = '1;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (cs_on && ch_q == c[0]) IDE_CS_n[2*c +: 2] = cs_q;
  end

endmodule

// File: tb/tb_ata_pio_ctrl.sv
// Directed bench: dut_a = two channels, default timing;
// dut_b = one channel, IORDY_TIMEOUT=4. Both see the same CPU bus stimulus.
module tb_ata_pio_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:12] addr = 12'hE90;
  logic rw_n = 1'b1;
  logic as_n = 1'b1;
  logic iordy = 1'b1;
  logic [7:0] base = 8'hE9;
  logic cfg_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ata_pio_ctrl_if bus_a ();
  ata_pio_ctrl_if bus_b ();
  assign bus_a.A = addr;  assign bus_a.RW_n = rw_n;  assign bus_a.AS_CPU_n = as_n;
  assign bus_b.A = addr;  assign bus_b.RW_n = rw_n;  assign bus_b.AS_CPU_n = as_n;

  logic rom_a, ior_a, iow_a, acc_a, to_a, rom_b, ior_b, iow_b, acc_b, to_b;
  logic [3:0] cs_a;
  logic [1:0] cs_b;

  ata_pio_ctrl #(.NUM_CHANNELS(2)) dut_a (
    .C14M(clk), .RESET(rst), .bus(bus_a), .BASE_IDE(base),
    .IDE_CONFIGURED_n(cfg_n), .IDE_IORDY(iordy), .ROM_OE_n(rom_a),
    .IDE_IOR_n(ior_a), .IDE_IOW_n(iow_a), .IDE_CS_n(cs_a),
    .IDE_ACCESS(acc_a), .IDE_TIMEOUT(to_a));

  ata_pio_ctrl #(.NUM_CHANNELS(1), .IORDY_TIMEOUT(4)) dut_b (
    .C14M(clk), .RESET(rst), .bus(bus_b), .BASE_IDE(base),
    .IDE_CONFIGURED_n(cfg_n), .IDE_IORDY(iordy), .ROM_OE_n(rom_b),
    .IDE_IOR_n(ior_b), .IDE_IOW_n(iow_b), .IDE_CS_n(cs_b),
    .IDE_ACCESS(acc_b), .IDE_TIMEOUT(to_b));

  logic [1:0] rom_v, ior_v, iow_v, dt_v, acc_v, to_v;
  assign rom_v = {rom_b, rom_a};
  assign ior_v = {ior_b, ior_a};
  assign iow_v = {iow_b, iow_a};
  assign dt_v  = {bus_b.DTACK_n, bus_a.DTACK_n};
  assign acc_v = {acc_b, acc_a};
  assign to_v  = {to_b, to_a};

  // Per-cycle observations, [0] = dut_a, [1] = dut_b. Counts stop at DTACK.
  int rom_n[2], ior_n[2], iow_n[2], hold_n[2];
  bit dt_seen[2], acc_seen[2], stb_seen[2];
  logic [3:0] csmin_a;
  logic [1:0] csmin_b;

  // Runs one CPU cycle until the chosen DUT acknowledges, then negates AS.
  // rdy_after >= 0 raises IORDY that many cycles after dut_a's strobe starts.
  task automatic run_cycle(input logic [23:12] ad, input logic rw, input int sel,
                           input int rdy_after, input int max_cyc, output bit timed_out);
    int s;
    bit done;
    s = -1;
    done = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rom_n[d] = 0; ior_n[d] = 0; iow_n[d] = 0; hold_n[d] = 0;
      dt_seen[d] = 0; acc_seen[d] = 0; stb_seen[d] = 0;
    end
    csmin_a = '1;
    csmin_b = '1;
    @(negedge clk);
    addr = ad;
    rw_n = rw;
    as_n = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (acc_v[d] === 1'b1) acc_seen[d] = 1;
        if (dt_v[d] === 1'b0) dt_seen[d] = 1;
        else if (!dt_seen[d]) begin
          if (rom_v[d] === 1'b0) rom_n[d]++;
          if (ior_v[d] === 1'b0 || iow_v[d] === 1'b0) begin
            stb_seen[d] = 1;
            if (ior_v[d] === 1'b0) ior_n[d]++;
            if (iow_v[d] === 1'b0) iow_n[d]++;
          end else if (stb_seen[d]) hold_n[d]++;
        end
      end
      csmin_a = csmin_a & cs_a;
      csmin_b = csmin_b & cs_b;
      if (s < 0 && (ior_a === 1'b0 || iow_a === 1'b0)) s = i;
      if (rdy_after >= 0 && s >= 0 && i == s + rdy_after) iordy = 1'b1;
      if (dt_v[sel] === 1'b0) done = 1'b1;
    end
    timed_out = !done;
    as_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rst = 1'b1;
    as_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rom_v, ior_v, iow_v, dt_v} !== 8'hFF) begin
      n_bad++;
      $display("FAIL reset_strobes got %b want ff", {rom_v, ior_v, iow_v, dt_v});
    end
    n_cmp++;
    if ({cs_a, cs_b, acc_v, to_v} !== 10'b1111_11_00_00) begin
      n_bad++;
      $display("FAIL reset_cs_flags got %b want 1111110000", {cs_a, cs_b, acc_v, to_v});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rom_read;
    bit to;
    run_cycle(12'hE90, 1'b1, 0, -1, 40, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL rom_dtack got none want ack"); end
    n_cmp++;
    if (rom_n[0] !== 2 || rom_n[1] !== 2) begin
      n_bad++;
      $display("FAIL rom_oe_cycles got %0d/%0d want 2/2", rom_n[0], rom_n[1]);
    end
    n_cmp++;
    if (ior_n[0] + iow_n[0] !== 0 || csmin_a !== 4'hF || acc_seen[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL rom_ide_quiet got strobes=%0d cs=%b acc=%0d want 0 1111 0",
               ior_n[0] + iow_n[0], csmin_a, acc_seen[0]);
    end
    n_cmp++;
    if ({rom_v, dt_v} !== 4'hF) begin
      n_bad++;
      $display("FAIL rom_release got %b want 1111", {rom_v, dt_v});
    end
  endtask

  task automatic test_write_read;
    bit to;
    iordy = 1'b1;
    run_cycle(12'hE91, 1'b0, 0, -1, 40, to);
    n_cmp++;
    if (to || iow_n[0] !== 3 || ior_n[0] !== 0) begin
      n_bad++;
      $display("FAIL wr_strobe got iow=%0d ior=%0d tmo=%0d want 3 0 0", iow_n[0], ior_n[0], to);
    end
    n_cmp++;
    if (csmin_a !== 4'b1110 || csmin_b !== 2'b10 || hold_n[0] !== 1 || acc_seen[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_cs_hold got cs=%b/%b hold=%0d acc=%0d want 1110/10 1 1",
               csmin_a, csmin_b, hold_n[0], acc_seen[0]);
    end
    run_cycle(12'hE91, 1'b1, 0, -1, 40, to);
    n_cmp++;
    if (to || ior_n[0] !== 3 || iow_n[0] !== 0 || rom_n[0] !== 0) begin
      n_bad++;
      $display("FAIL rd_after_wr got ior=%0d iow=%0d rom=%0d want 3 0 0",
               ior_n[0], iow_n[0], rom_n[0]);
    end
  endtask

  task automatic test_iordy_wait;
    bit to;
    iordy = 1'b0;
    run_cycle(12'hE91, 1'b1, 0, 10, 60, to);
    n_cmp++;
    if (to || ior_n[0] < 11 || ior_n[0] > 13) begin
      n_bad++;
      $display("FAIL iordy_wait got ior=%0d tmo=%0d want 11..13 0", ior_n[0], to);
    end
    n_cmp++;
    if (hold_n[0] !== 1 || to_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL iordy_hold got hold=%0d timeout=%b want 1 0", hold_n[0], to_v[0]);
    end
  endtask

  task automatic test_timeout;
    bit to;
    pulse_reset();
    iordy = 1'b0;
    run_cycle(12'hE91, 1'b0, 1, -1, 60, to);
    n_cmp++;
    if (to || iow_n[1] !== 7 || hold_n[1] !== 1) begin
      n_bad++;
      $display("FAIL tmo_strobe got iow=%0d hold=%0d tmo=%0d want 7 1 0", iow_n[1], hold_n[1], to);
    end
    n_cmp++;
    if (to_v !== 2'b10) begin
      n_bad++;
      $display("FAIL tmo_flag got %b want 10", to_v);
    end
    iordy = 1'b1;
    run_cycle(12'hE91, 1'b0, 1, -1, 40, to);
    n_cmp++;
    if (to || iow_n[1] !== 3 || to_v !== 2'b10) begin
      n_bad++;
      $display("FAIL tmo_sticky got iow=%0d flag=%b want 3 10", iow_n[1], to_v);
    end
    pulse_reset();
    n_cmp++;
    if (to_v !== 2'b00) begin
      n_bad++;
      $display("FAIL tmo_clear got %b want 00", to_v);
    end
  endtask

  task automatic test_two_channel;
    bit to;
    iordy = 1'b1;
    run_cycle(12'hE96, 1'b0, 0, -1, 40, to);
    n_cmp++;
    if (to || csmin_a !== 4'b0111 || csmin_b !== 2'b01) begin
      n_bad++;
      $display("FAIL ch1_cs got cs=%b/%b tmo=%0d want 0111/01 0", csmin_a, csmin_b, to);
    end
  endtask

  task automatic test_abort;
    bit seen_dt, hit_stb;
    int s_cnt;
    // AS negated during the strobe.
    iordy = 1'b0;
    seen_dt = 0;
    hit_stb = 0;
    @(negedge clk);
    addr = 12'hE91; rw_n = 1'b0; as_n = 1'b0;
    for (int i = 0; i < 40 && !hit_stb; i++) begin
      @(negedge clk);
      if (iow_a === 1'b0) hit_stb = 1;
    end
    n_cmp++;
    if (!hit_stb) begin n_bad++; $display("FAIL abort_start got no strobe want strobe"); end
    as_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dt_v !== 2'b11) seen_dt = 1;
    end
    n_cmp++;
    if (seen_dt || iow_v !== 2'b11 || to_v !== 2'b00 || cs_a !== 4'hF) begin
      n_bad++;
      $display("FAIL abort_as got dtack=%0d iow=%b tmo=%b cs=%b want 0 11 00 1111",
               seen_dt, iow_v, to_v, cs_a);
    end
    // RESET pulsed while waiting for IORDY.
    hit_stb = 0;
    seen_dt = 0;
    s_cnt = 0;
    as_n = 1'b0;
    for (int i = 0; i < 40 && s_cnt < 6; i++) begin
      @(negedge clk);
      if (dt_v !== 2'b11) seen_dt = 1;
      if (iow_a === 1'b0) s_cnt++;
    end
    n_cmp++;
    if (s_cnt !== 6 || iow_v !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_wait_entry got cycles=%0d iow=%b want 6 00", s_cnt, iow_v);
    end
    rst = 1'b1;
    as_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (seen_dt || {iow_v, dt_v, acc_v} !== 6'b11_11_00 || cs_a !== 4'hF) begin
      n_bad++;
      $display("FAIL rst_abort got dtack=%0d out=%b cs=%b want 0 111100 1111",
               seen_dt, {iow_v, dt_v, acc_v}, cs_a);
    end
    iordy = 1'b1;
    repeat (3) @(negedge clk);
    begin
      bit to;
      run_cycle(12'hE91, 1'b1, 0, -1, 40, to);
      n_cmp++;
      if (to || rom_n[0] !== 2 || ior_n[0] !== 0 || acc_seen[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_overlay got rom=%0d ior=%0d acc=%0d want 2 0 0",
                 rom_n[0], ior_n[0], acc_seen[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_write_read();
    test_iordy_wait();
    test_timeout();
    test_two_channel();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
